// File: rtl/cmd_capture_fifo.sv
// Capture stage for the cmd FSM count output: once armed by the FSM's reset-seen flag,
// every change of the count is queued into a small show-ahead FIFO; overflow is dropped and counted.
module cmd_capture_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  iClock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] iValue,
  input  logic                  iArm,
  input  logic                  iPop,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oFull,
  output logic [ADDR_WIDTH:0]   oLevel,
  output logic [DROP_WIDTH-1:0] oDrops,
  output logic                  oArmed
);

  localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LEVEL_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] DROP_ONE   = DROP_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   level_reg;
  logic [DROP_WIDTH-1:0] drops_reg;
  logic                  armed_reg, primed_reg;
  logic [DATA_WIDTH-1:0] last_reg;

  logic empty, full, evt, push, pop, write_en, drop;

  assign empty    = (level_reg == '0);
  assign full     = (level_reg == FULL_LEVEL);
  assign evt      = armed_reg & primed_reg & (iValue != last_reg);
  assign push     = evt;
  assign pop      = iPop & ~empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign write_en = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_ff @(posedge iClock) begin
    if (Reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      drops_reg  <= '0;
      armed_reg  <= 1'b0;
      primed_reg <= 1'b0;
      last_reg   <= '0;
    end else begin
      primed_reg <= 1'b1;
      last_reg   <= iValue;
      if (iArm) begin
        armed_reg <= 1'b1;
      end
      if (write_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (write_en && !pop) begin
        level_reg <= level_reg + LEVEL_ONE;
      end else if (pop && !write_en) begin
        level_reg <= level_reg - LEVEL_ONE;
      end
      if (drop && (drops_reg != '1)) begin
        drops_reg <= drops_reg + DROP_ONE;
      end
    end
  end

  // Storage is deliberately left uncleared on reset; the output gate hides stale contents.
  always_ff @(posedge iClock) begin
    if (!Reset && write_en) begin
      mem[wr_ptr_reg] <= iValue;
    end
  end

  assign oData  = empty ? '0 : mem[rd_ptr_reg];
  assign oValid = ~empty;
  assign oFull  = full;
  assign oLevel = level_reg;
  assign oDrops = drops_reg;
  assign oArmed = armed_reg;

endmodule

// File: tb/tb_cmd_capture_fifo.sv
// Self-checking bench for cmd_capture_fifo: directed vector table followed by a flood
// phase and randomized traffic compared against a queue-based reference model.
module tb_cmd_capture_fifo;

  logic        iClock;
  logic        Reset;
  logic [31:0] iValue;
  logic        iArm;
  logic        iPop;
  logic [31:0] oData;
  logic        oValid;
  logic        oFull;
  logic [2:0]  oLevel;
  logic [7:0]  oDrops;
  logic        oArmed;

  cmd_capture_fifo #(
    .DATA_WIDTH(32),
    .DEPTH(4),
    .ADDR_WIDTH(2),
    .DROP_WIDTH(8)
  ) dut (
    .iClock(iClock),
    .Reset(Reset),
    .iValue(iValue),
    .iArm(iArm),
    .iPop(iPop),
    .oData(oData),
    .oValid(oValid),
    .oFull(oFull),
    .oLevel(oLevel),
    .oDrops(oDrops),
    .oArmed(oArmed)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  typedef struct {
    logic        rst;
    logic        arm;
    logic        pop;
    logic [31:0] val;
    int          lvl;
    logic [31:0] data;
    int          drops;
    logic        armed;
  } vec_t;

  vec_t vecs[$];
  int   total;
  int   passed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic a, input logic p, input logic [31:0] v,
                     input int l, input logic [31:0] d, input int dr, input logic arm_e);
    vec_t x;
    x.rst = r; x.arm = a; x.pop = p; x.val = v;
    x.lvl = l; x.data = d; x.drops = dr; x.armed = arm_e;
    vecs.push_back(x);
  endtask

  task automatic step(input logic r, input logic a, input logic p, input logic [31:0] v);
    Reset = r; iArm = a; iPop = p; iValue = v;
    @(posedge iClock);
    #1;
  endtask

  task automatic check_all(input string tag, input int lvl, input logic [31:0] data,
                           input int drops, input logic armed);
    chk({tag, " level"}, 32'(oLevel), 32'(lvl));
    chk({tag, " data"},  oData, data);
    chk({tag, " valid"}, 32'(oValid), 32'(lvl != 0));
    chk({tag, " full"},  32'(oFull), 32'(lvl == 4));
    chk({tag, " drops"}, 32'(oDrops), 32'(drops));
    chk({tag, " armed"}, 32'(oArmed), 32'(armed));
  endtask

  // Reference model state
  logic [31:0] mq[$];
  logic        m_armed, m_primed;
  logic [31:0] m_last;
  int          m_drops;

  task automatic model_edge(input logic r, input logic a, input logic p, input logic [31:0] v);
    logic ev;
    if (r) begin
      mq.delete();
      m_armed = 0; m_primed = 0; m_last = 0; m_drops = 0;
    end else begin
      ev = m_armed && m_primed && (v != m_last);
      if (p && mq.size() > 0) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < 4) mq.push_back(v);
        else if (m_drops < 255) m_drops++;
      end
      if (a) m_armed = 1;
      m_primed = 1;
      m_last = v;
    end
  endtask

  task automatic rand_cycle(input string tag, input logic r, input logic a, input logic p,
                            input logic [31:0] v);
    step(r, a, p, v);
    model_edge(r, a, p, v);
    check_all(tag, mq.size(), (mq.size() > 0) ? mq[0] : 32'h0, m_drops, m_armed);
  endtask

  initial begin
    logic [31:0] v;
    logic        r, a, p;
    total = 0; passed = 0;
    Reset = 1'b1; iArm = 1'b1; iPop = 1'b0; iValue = 32'hFFFF_FFFF;

    // rst arm pop value  | level data drops armed
    add(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(0, 0, 0, 0,  0, 0, 0, 0);   // prime edge
    add(0, 0, 0, 1,  0, 0, 0, 0);
    add(0, 0, 0, 2,  0, 0, 0, 0);
    add(0, 1, 0, 2,  0, 0, 0, 1);   // arm edge captures nothing
    add(0, 0, 0, 3,  1, 3, 0, 1);
    add(0, 0, 1, 3,  0, 0, 0, 1);
    add(0, 0, 0, 10, 1, 10, 0, 1);
    add(0, 0, 0, 11, 2, 10, 0, 1);
    add(0, 0, 0, 12, 3, 10, 0, 1);
    add(0, 0, 0, 13, 4, 10, 0, 1);
    add(0, 0, 0, 14, 4, 10, 1, 1);
    add(0, 0, 0, 15, 4, 10, 2, 1);
    add(0, 0, 1, 20, 4, 11, 2, 1);  // push+pop at full
    add(0, 0, 1, 20, 3, 12, 2, 1);
    add(0, 0, 1, 20, 2, 13, 2, 1);
    add(0, 0, 1, 20, 1, 20, 2, 1);
    add(0, 0, 1, 20, 0, 0, 2, 1);
    add(0, 0, 1, 20, 0, 0, 2, 1);   // pop on empty ignored
    add(0, 0, 0, 21, 1, 21, 2, 1);
    add(0, 0, 0, 21, 1, 21, 2, 1);  // repeat not captured
    add(0, 0, 1, 22, 1, 22, 2, 1);
    add(0, 0, 1, 22, 0, 0, 2, 1);
    add(0, 0, 0, 30, 1, 30, 2, 1);
    add(0, 0, 0, 31, 2, 30, 2, 1);
    add(0, 0, 0, 32, 3, 30, 2, 1);
    add(1, 1, 0, 33, 0, 0, 0, 0);   // mid-operation reset flushes
    add(0, 0, 0, 34, 0, 0, 0, 0);
    add(0, 0, 0, 35, 0, 0, 0, 0);
    add(0, 1, 0, 35, 0, 0, 0, 1);
    add(0, 0, 0, 36, 1, 36, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].arm, vecs[i].pop, vecs[i].val);
      $display("vec %0d: rst=%0b arm=%0b pop=%0b val=%0h -> level=%0d data=%0h drops=%0d armed=%0b",
               i, vecs[i].rst, vecs[i].arm, vecs[i].pop, vecs[i].val, oLevel, oData, oDrops, oArmed);
      check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].data, vecs[i].drops, vecs[i].armed);
    end

    // Flood: constant changes with no pops drive the drop counter into saturation.
    for (int i = 0; i < 300; i++) begin
      rand_cycle($sformatf("flood%0d", i), (i == 0), 1'b1, 1'b0, 32'(1000 + i));
    end
    $display("flood done: level=%0d drops=%0d", oLevel, oDrops);
    chk("drops saturated", 32'(oDrops), 32'd255);

    // Random traffic with frequent repeats and occasional resets.
    v = 0;
    for (int i = 0; i < 600; i++) begin
      r = (i == 0) || ($urandom_range(0, 49) == 0);
      a = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) != 0) v = 32'($urandom_range(0, 15));
      rand_cycle($sformatf("rand%0d", i), r, a, p, v);
    end
    $display("random done: level=%0d drops=%0d armed=%0b", oLevel, oDrops, oArmed);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cmd_capture_fifo.md
# cmd_capture_fifo

Downstream capture stage for the `cmd` control FSM. It watches the FSM's 32-bit count output and the reset-seen flag, and arms itself once the FSM reports passing through reset. It then queues every change of the count value into a small show-ahead FIFO with a pop handshake, so a consumer (bench checker or later datapath stage) can drain the FSM's count history without missing values. Overflow is dropped and counted.

## Interface
Parameters:
- DATA_WIDTH, 32, width of captured value (matches FSM count output)
- DEPTH, 4, FIFO entries; power of two, ≥2
- ADDR_WIDTH, 2, log2(DEPTH)
- DROP_WIDTH, 8, width of saturating drop counter

Ports:
- iClock  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- iValue  in  DATA_WIDTH  count value from FSM (`o1`)
- iArm  in  1  reset-seen flag from FSM (`pasee_por_reset`)
- iPop  in  1  consumer pop request; honoured only when oValid=1
- oData  out  DATA_WIDTH  head entry (show-ahead); 0 when empty
- oValid  out  1  FIFO non-empty
- oFull  out  1  level == DEPTH
- oLevel  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH
- oDrops  out  DROP_WIDTH  events lost to overflow, saturating
- oArmed  out  1  capture enabled

## Operation
- Reset (edge with Reset=1): write/read pointers, oLevel, oDrops, oArmed, rPrimed and rLast all cleared to 0. Memory is not cleared; oData is gated to 0 while empty. iArm, iValue and iPop are ignored on reset edges. Reset mid-operation flushes all queued entries at that edge.
- Arm: oArmed sets at the first non-reset edge with iArm=1 and stays set until Reset.
- Prime: rPrimed sets at the first non-reset edge after Reset; rLast <= iValue on every non-reset edge.
- Event (combinational): evt = oArmed & rPrimed & (iValue != rLast).
- Push = evt. Pop = iPop & oValid.
- FIFO actions per edge:
  - Push only, not full: write iValue at wr_ptr; wr_ptr+1 (wraps mod DEPTH); level+1.
  - Push only, full: value discarded; oDrops+1, saturating at all-ones; pointers and level unchanged.
  - Pop only: rd_ptr+1 (wraps); level-1.
  - Push and pop, level ≥1 (including full): write and read both advance; level unchanged; no drop.
  - Push with empty FIFO and iPop=1: push only (pop ignored, oValid=0).
  - Pop request when empty: ignored.
- oData = mem[rd_ptr] when level≠0, else 0. oValid = (level≠0). oFull = (level==DEPTH).
- Pointers are ADDR_WIDTH bits and wrap naturally; level is tracked separately (ADDR_WIDTH+1 bits).

## Timing
- Capture latency: an iValue change present before edge N (armed, primed) appears in the FIFO after edge N. If the FIFO was empty, oValid=1 and oData=new value in the cycle after edge N.
- Edge with iArm=1 that sets oArmed does not itself capture; capture starts at the next edge.
- A change coinciding with the prime edge is not captured (rLast not yet valid).
- Pop: with oValid=1 and iPop=1 at edge N, oData shows the next entry (or 0 if now empty) after edge N.
- All outputs are registered state or combinational from registered state only; there is no combinational path from inputs to outputs.

## Test plan
- Reset values: hold Reset 3 cycles with iValue=32'hFFFF_FFFF, iArm=1 -> oData=0, oValid=0, oFull=0, oLevel=0, oDrops=0, oArmed=0.
- Arm gating: release Reset, step iValue 0->1->2 with iArm=0 -> nothing captured; pulse iArm, then step 2->3 -> oArmed=1, oLevel=1, oData=3 one cycle after the edge.
- Fill and overflow: armed, iPop=0, iValue 10,11,12,13,14,15 on consecutive cycles -> oLevel=4, oFull=1, oData=10, oDrops=2.
- Simultaneous push/pop at full: full with 10..13, iValue 20 with iPop=1 -> oLevel stays 4, oDrops unchanged, drained order is 11,12,13,20, then oValid=0, oData=0.
- Wrap-around and repeats: 9 push/pop pairs with iValue held twice between steps -> duplicates not captured; FIFO order preserved across pointer wrap.
- Reset mid-operation: oLevel=3, assert Reset 1 cycle -> next cycle oLevel=0, oValid=0, oArmed=0, oDrops=0; no capture until re-armed.
